// File: rtl/poly_cmd_loader_pkg.sv
// Shared constants, opcodes, FSM states and the polygon record layout
// for the polygon command loader.
package poly_cmd_loader_pkg;

  localparam int N_POLY      = 6;
  localparam int WPX         = 10;
  localparam int WPY         = 9;
  localparam int WCOLOR      = 6;
  localparam int WPOLY_BYTES = 8;

  // Slot numbers at or above this value have no storage behind them.
  localparam logic [2:0] SLOT_LIMIT = 3'(N_POLY);

  typedef enum logic [1:0] {
    OP_WPOLY = 2'b00,
    OP_SETEN = 2'b01,
    OP_SETBG = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_APPLY
  } deser_state_e;

  // Low 63 bits of the WRITE_POLY word; the pad bit (63) is never stored.
  typedef struct packed {
    logic [WCOLOR-1:0] color;
    logic [WPY-1:0]    v2_y;
    logic [WPX-1:0]    v2_x;
    logic [WPY-1:0]    v1_y;
    logic [WPX-1:0]    v1_x;
    logic [WPY-1:0]    v0_y;
    logic [WPX-1:0]    v0_x;
  } poly_t;

  function automatic logic [3:0] payload_len(input op_e op);
    return (op == OP_WPOLY) ? 4'(WPOLY_BYTES) : 4'd1;
  endfunction

endpackage

// File: rtl/poly_cmd_loader_if.sv
// Byte-stream command port: valid/ready handshake, one byte per beat.
interface poly_cmd_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/poly_cmd_loader_deser.sv
// Header decode and payload deserialiser. Collects a command's payload
// bytes MSB first and raises a one-cycle apply strobe with op/slot/word.
//
// state      | meaning
// ST_IDLE    | waiting for a header byte
// ST_PAYLOAD | shifting payload bytes into the accumulator
// ST_APPLY   | accumulator complete; apply strobe high, input stalled
module poly_cmd_loader_deser
  import poly_cmd_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  poly_cmd_loader_if.slave          cmd,
  output logic                      o_apply,
  output op_e                       o_op,
  output logic [2:0]                o_slot,
  output logic [62:0]               o_word
);

  deser_state_e r_state;
  deser_state_e w_state_nxt;
  logic         r_rdy_en;
  logic [3:0]   r_cnt;
  logic [62:0]  r_acc;
  op_e          r_op;
  logic [2:0]   r_slot;
  logic         w_accept;
  op_e          w_hdr_op;

  // r_rdy_en keeps in_ready low until the first clock after reset release.
  assign cmd.in_ready = r_rdy_en & (r_state != ST_APPLY);
  assign w_accept     = cmd.in_valid & cmd.in_ready;
  assign w_hdr_op     = op_e'(cmd.in_data[7:6]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept && (w_hdr_op != OP_NOP)) w_state_nxt = ST_PAYLOAD;
      ST_PAYLOAD: if (w_accept && (r_cnt == 4'd1))      w_state_nxt = ST_APPLY;
      ST_APPLY:   w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Header capture, byte down-counter and accumulator. Only the low 63
  // bits are kept, so the WRITE_POLY pad bit falls off the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_op     <= OP_WPOLY;
      r_slot   <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if ((r_state == ST_IDLE) && w_accept) begin
        r_op   <= w_hdr_op;
        r_slot <= cmd.in_data[2:0];
        r_cnt  <= payload_len(w_hdr_op);
        r_acc  <= '0;
      end else if ((r_state == ST_PAYLOAD) && w_accept) begin
        r_acc <= {r_acc[54:0], cmd.in_data};
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign o_apply = (r_state == ST_APPLY);
  assign o_op    = r_op;
  assign o_slot  = r_slot;
  assign o_word  = r_acc;

endmodule

// File: rtl/poly_cmd_loader.sv
// Polygon command loader: shadow register file written by host commands,
// copied wholesale to the active set on frame_start so the pixel core
// never sees a half-updated frame.
module poly_cmd_loader
  import poly_cmd_loader_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  poly_cmd_loader_if.slave           cmd,
  input  logic                       frame_start,
  output logic [N_POLY-1:0]          cmp_en,
  output logic [WCOLOR-1:0]          background_color,
  output logic [WCOLOR*N_POLY-1:0]   poly_color,
  output logic [WPX*N_POLY-1:0]      v0_x,
  output logic [WPX*N_POLY-1:0]      v1_x,
  output logic [WPX*N_POLY-1:0]      v2_x,
  output logic [WPY*N_POLY-1:0]      v0_y,
  output logic [WPY*N_POLY-1:0]      v1_y,
  output logic [WPY*N_POLY-1:0]      v2_y,
  output logic                       committed,
  output logic                       cmd_err
);

  logic              w_apply;
  op_e               w_op;
  logic [2:0]        w_slot;
  logic [62:0]       w_word;
  logic              w_slot_ok;

  poly_t             r_sh_poly  [N_POLY];
  poly_t             r_act_poly [N_POLY];
  logic [N_POLY-1:0] r_sh_en, r_act_en;
  logic [WCOLOR-1:0] r_sh_bg, r_act_bg;
  logic              r_committed;

  poly_cmd_loader_deser u_deser (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (cmd),
    .o_apply (w_apply),
    .o_op    (w_op),
    .o_slot  (w_slot),
    .o_word  (w_word)
  );

  assign w_slot_ok = (w_slot < SLOT_LIMIT);
  assign cmd_err   = w_apply & (w_op == OP_WPOLY) & ~w_slot_ok;

  // Shadow writes from the apply strobe; out-of-range slots are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_POLY; i++) r_sh_poly[i] <= '0;
      r_sh_en <= '0;
      r_sh_bg <= '0;
    end else if (w_apply) begin
      case (w_op)
        OP_WPOLY: if (w_slot_ok) r_sh_poly[w_slot] <= poly_t'(w_word);
        OP_SETEN: r_sh_en <= w_word[N_POLY-1:0];
        OP_SETBG: r_sh_bg <= w_word[WCOLOR-1:0];
        default:  ;
      endcase
    end
  end

  // Commit: active takes the pre-write shadow when frame_start and an
  // apply coincide, because both sample the shadow before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_POLY; i++) r_act_poly[i] <= '0;
      r_act_en    <= '0;
      r_act_bg    <= '0;
      r_committed <= 1'b0;
    end else begin
      r_committed <= frame_start;
      if (frame_start) begin
        for (int i = 0; i < N_POLY; i++) r_act_poly[i] <= r_sh_poly[i];
        r_act_en <= r_sh_en;
        r_act_bg <= r_sh_bg;
      end
    end
  end

  assign committed        = r_committed;
  assign cmp_en           = r_act_en;
  assign background_color = r_act_bg;

  for (genvar i = 0; i < N_POLY; i++) begin : g_pack
    assign poly_color[i*WCOLOR +: WCOLOR] = r_act_poly[i].color;
    assign v0_x[i*WPX +: WPX]             = r_act_poly[i].v0_x;
    assign v1_x[i*WPX +: WPX]             = r_act_poly[i].v1_x;
    assign v2_x[i*WPX +: WPX]             = r_act_poly[i].v2_x;
    assign v0_y[i*WPY +: WPY]             = r_act_poly[i].v0_y;
    assign v1_y[i*WPY +: WPY]             = r_act_poly[i].v1_y;
    assign v2_y[i*WPY +: WPY]             = r_act_poly[i].v2_y;
  end

endmodule

// File: tb/tb_poly_cmd_loader.sv
// Self-checking bench for poly_cmd_loader: a reference model of the
// shadow/active files feeds an expected-output queue that is popped and
// compared whenever the DUT commits (or is sampled before a commit).
module tb_poly_cmd_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [5:0]  cmp_en, background_color;
  logic [35:0] poly_color;
  logic [59:0] v0_x, v1_x, v2_x;
  logic [53:0] v0_y, v1_y, v2_y;
  logic        committed, cmd_err;

  poly_cmd_loader_if cmd();

  poly_cmd_loader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd              (cmd),
    .frame_start      (frame_start),
    .cmp_en           (cmp_en),
    .background_color (background_color),
    .poly_color       (poly_color),
    .v0_x             (v0_x),
    .v1_x             (v1_x),
    .v2_x             (v2_x),
    .v0_y             (v0_y),
    .v1_y             (v1_y),
    .v2_y             (v2_y),
    .committed        (committed),
    .cmd_err          (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  en;
    logic [5:0]  bg;
    logic [35:0] col;
    logic [59:0] v0x, v1x, v2x;
    logic [53:0] v0y, v1y, v2y;
  } exp_t;

  exp_t        exp_q[$];
  logic [62:0] m_sh_w[6];
  logic [62:0] m_act_w[6];
  logic [5:0]  m_sh_en, m_act_en, m_sh_bg, m_act_bg;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] mk_word(input logic [9:0] v0x, input logic [8:0] v0y,
                                          input logic [9:0] v1x, input logic [8:0] v1y,
                                          input logic [9:0] v2x, input logic [8:0] v2y,
                                          input logic [5:0] c);
    return {1'b0, c, v2y, v2x, v1y, v1x, v0y, v0x};
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.en = m_act_en;
    e.bg = m_act_bg;
    for (int i = 0; i < 6; i++) begin
      e.v0x[i*10 +: 10] = m_act_w[i][9:0];
      e.v0y[i*9  +: 9]  = m_act_w[i][18:10];
      e.v1x[i*10 +: 10] = m_act_w[i][28:19];
      e.v1y[i*9  +: 9]  = m_act_w[i][37:29];
      e.v2x[i*10 +: 10] = m_act_w[i][47:38];
      e.v2y[i*9  +: 9]  = m_act_w[i][56:48];
      e.col[i*6  +: 6]  = m_act_w[i][62:57];
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_sh_w[i]  = '0;
      m_act_w[i] = '0;
    end
    m_sh_en = '0; m_act_en = '0; m_sh_bg = '0; m_act_bg = '0;
  endtask

  task automatic model_commit();
    for (int i = 0; i < 6; i++) m_act_w[i] = m_sh_w[i];
    m_act_en = m_sh_en;
    m_act_bg = m_sh_bg;
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [2:0] slot, input logic [63:0] w);
    case (op)
      2'b00: if (slot < 3'd6) m_sh_w[slot] = w[62:0];
      2'b01: m_sh_en = w[5:0];
      2'b10: m_sh_bg = w[5:0];
      default: ;
    endcase
  endtask

  task automatic cmp_out(input string tag);
    exp_t e;
    chk({tag, "_qlen"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_en"},  64'(cmp_en), 64'(e.en));
      chk({tag, "_bg"},  64'(background_color), 64'(e.bg));
      chk({tag, "_col"}, 64'(poly_color), 64'(e.col));
      chk({tag, "_v0x"}, 64'(v0_x), 64'(e.v0x));
      chk({tag, "_v1x"}, 64'(v1_x), 64'(e.v1x));
      chk({tag, "_v2x"}, 64'(v2_x), 64'(e.v2x));
      chk({tag, "_v0y"}, 64'(v0_y), 64'(e.v0y));
      chk({tag, "_v1y"}, 64'(v1_y), 64'(e.v1y));
      chk({tag, "_v2y"}, 64'(v2_y), 64'(e.v2y));
    end
  endtask

  // Entered and left just after a falling edge; valid stays high between bytes.
  task automatic send_byte(input logic [7:0] b);
    int waitc = 0;
    cmd.in_data  = b;
    cmd.in_valid = 1'b1;
    while (!cmd.in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 20) chk("rdy_wait", 64'(cmd.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [63:0] pl, input bit fs_in_apply);
    int n;
    n = (hdr[7:6] == 2'b00) ? 8 : ((hdr[7:6] == 2'b11) ? 0 : 1);
    send_byte(hdr);
    for (int i = 0; i < n; i++) send_byte(pl[8*(n-1-i) +: 8]);
    cmd.in_valid = 1'b0;
    if (n > 0) begin
      chk("rdy_apply", 64'(cmd.in_ready), 64'd0);
      chk("cmd_err_apply", 64'(cmd_err), 64'((hdr[7:6] == 2'b00) && (hdr[2:0] >= 3'd6)));
      if (fs_in_apply) begin
        frame_start = 1'b1;
        model_commit();
        exp_q.push_back(model_out());
      end
      model_apply(hdr[7:6], hdr[2:0], pl);
      @(posedge clk);
      @(negedge clk);
      chk("cmd_err_after", 64'(cmd_err), 64'd0);
      if (fs_in_apply) begin
        frame_start = 1'b0;
        chk("committed_apply", 64'(committed), 64'd1);
        cmp_out("fs_apply");
      end
    end
  endtask

  task automatic do_frame(input string tag);
    frame_start = 1'b1;
    model_commit();
    exp_q.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
    frame_start = 1'b0;
    chk({tag, "_committed"}, 64'(committed), 64'd1);
    cmp_out(tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_committed_off"}, 64'(committed), 64'd0);
  endtask

  logic [63:0] w2, w5, w7;

  initial begin
    cmd.in_data  = '0;
    cmd.in_valid = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rdy_in_rst", 64'(cmd.in_ready), 64'd0);
    chk("committed_rst", 64'(committed), 64'd0);
    chk("cmd_err_rst", 64'(cmd_err), 64'd0);
    exp_q.push_back(model_out());
    cmp_out("rst");
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rdy_after_rst", 64'(cmd.in_ready), 64'd1);

    // WRITE_POLY slot 2, invisible until frame_start
    w2 = mk_word(10'd10, 9'd20, 10'd300, 9'd20, 10'd150, 9'd400, 6'h30);
    send_pkt(8'h02, w2, 1'b0);
    exp_q.push_back(model_out());
    cmp_out("pre_frame");
    do_frame("poly2");
    chk("v0x_s2", 64'(v0_x[29:20]), 64'd10);
    chk("v2y_s2", 64'(v2_y[26:18]), 64'd400);
    chk("col_s2", 64'(poly_color[17:12]), 64'h30);

    // Highest valid slot, reserved header bits and pad bit set
    w5 = {$urandom(), $urandom()};
    w5[63] = 1'b1;
    send_pkt(8'h3D, w5, 1'b0);
    do_frame("poly5");

    // Enable mask and background, with a NOP in between
    send_pkt(8'h40, 64'h3F, 1'b0);
    send_pkt(8'hC5, 64'h0, 1'b0);
    send_pkt(8'h80, 64'h03, 1'b0);
    do_frame("en_bg");
    chk("cmp_en_3f", 64'(cmp_en), 64'h3F);
    chk("bg_03", 64'(background_color), 64'h03);

    // Out-of-range slot: error pulse, nothing written, next header accepted
    w7 = {$urandom(), $urandom()};
    send_pkt(8'h07, w7, 1'b0);
    do_frame("slot7");
    send_pkt(8'h81, 64'h05, 1'b0);
    do_frame("bg05");

    // frame_start coincides with the APPLY of SET_BG 0x0C
    send_pkt(8'h80, 64'h0C, 1'b1);
    chk("bg_old", 64'(background_color), 64'h05);
    do_frame("bg0c");
    chk("bg_0c", 64'(background_color), 64'h0C);

    // Reset mid-packet, then a clean SET_EN
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(8'hA5 + 8'(i));
    cmd.in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rdy_in_rst2", 64'(cmd.in_ready), 64'd0);
    exp_q.push_back(model_out());
    cmp_out("rst2");
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send_pkt(8'h40, 64'h01, 1'b0);
    do_frame("after_rst");
    chk("cmp_en_01", 64'(cmp_en), 64'h01);
    chk("q_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
